// File: rtl/adxl362_spi_reader.sv
// ADXL362 SPI master: one config write, then periodic 6-byte XYZ burst reads reduced to sign+4-bit magnitude.
// Latency: acl_data/data_valid update one cycle after cs_n rises at the end of each 129*CLK_DIV-cycle read frame.
// Backpressure: none; free-running. An overrun sample timer defers the next read until the CLK_DIV cs_n gap ends.
module adxl362_spi_reader #(
   parameter int CLK_DIV        = 50,
   parameter int SAMPLE_PERIOD  = 1_000_000,
   parameter int STARTUP_CYCLES = 1_000_000
) (
   input  logic        clk100mhz,
   input  logic        reset,
   input  logic        miso,
   output logic        sclk,
   output logic        mosi,
   output logic        cs_n,
   output logic [14:0] acl_data,
   output logic        data_valid,
   output logic        init_done
);

   localparam int DW = $clog2(CLK_DIV + 1);
   localparam int SW = $clog2(STARTUP_CYCLES + 1);
   localparam int TW = $clog2(SAMPLE_PERIOD + 1);

   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [SW-1:0] SU_LAST  = SW'(STARTUP_CYCLES - 1);
   localparam logic [TW-1:0] TMR_LAST = TW'(SAMPLE_PERIOD - 1);

   // Frames are left-aligned so the next bit to send is always bit 63.
   localparam logic [63:0] CFG_WORD  = {24'h0A_2D_02, 40'h0};
   localparam logic [63:0] READ_WORD = {16'h0B_0E, 48'h0};

   typedef enum logic [2:0] {
      S_STARTUP,
      S_CFG,
      S_CFG_GAP,
      S_READ,
      S_UPDATE,
      S_WAIT
   } state_t;

   state_t          state, state_nxt;
   logic [SW-1:0]   su_cnt, su_cnt_nxt;
   logic [DW-1:0]   div_cnt, div_cnt_nxt;
   logic [7:0]      ph, ph_nxt;         // half-bit phase: even = sclk low, odd = sclk high, 2N = trailing low
   logic [7:0]      ph_end;
   logic [63:0]     tx, tx_nxt;
   logic [47:0]     rx, rx_nxt;
   logic [TW-1:0]   tmr, tmr_nxt;
   logic            sclk_nxt, mosi_nxt, cs_n_nxt;
   logic [14:0]     acl_data_nxt;
   logic            data_valid_nxt, init_done_nxt;
   logic            start_read;

   // One axis: 12-bit two's complement -> {sign, |v| / 128}, with -2048 clamped to 2047.
   function automatic logic [4:0] axis_field(input logic [7:0] lo, input logic [7:0] hi);
      logic [11:0] v;
      logic [11:0] neg;
      logic [10:0] mag;
      v   = {hi[3:0], lo};
      neg = ~v + 12'd1;
      if (!v[11])
         mag = v[10:0];
      else if (v == 12'h800)
         mag = 11'h7FF;
      else
         mag = neg[10:0];
      return {v[11], mag[10:7]};
   endfunction

   assign ph_end = (state == S_READ) ? 8'd128 : 8'd48;

   // Next-state and next-output logic for the sequencer, SPI shifter and sample timer.
   always_comb begin
      state_nxt      = state;
      su_cnt_nxt     = su_cnt;
      div_cnt_nxt    = div_cnt;
      ph_nxt         = ph;
      tx_nxt         = tx;
      rx_nxt         = rx;
      tmr_nxt        = (tmr == TMR_LAST) ? tmr : tmr + TW'(1);
      sclk_nxt       = sclk;
      mosi_nxt       = mosi;
      cs_n_nxt       = cs_n;
      acl_data_nxt   = acl_data;
      data_valid_nxt = 1'b0;
      init_done_nxt  = init_done;
      start_read     = 1'b0;

      case (state)
         S_STARTUP: begin
            if (su_cnt == SU_LAST) begin
               state_nxt   = S_CFG;
               cs_n_nxt    = 1'b0;
               tx_nxt      = CFG_WORD;
               mosi_nxt    = CFG_WORD[63];
               div_cnt_nxt = '0;
               ph_nxt      = '0;
            end else begin
               su_cnt_nxt = su_cnt + SW'(1);
            end
         end

         S_CFG, S_READ: begin
            if (div_cnt != DIV_LAST) begin
               div_cnt_nxt = div_cnt + DW'(1);
            end else begin
               div_cnt_nxt = '0;
               if (ph == ph_end) begin
                  cs_n_nxt  = 1'b1;
                  sclk_nxt  = 1'b0;
                  mosi_nxt  = 1'b0;
                  state_nxt = (state == S_CFG) ? S_CFG_GAP : S_UPDATE;
               end else begin
                  ph_nxt = ph + 8'd1;
                  if (!ph[0]) begin
                     // Rising edge: capture the slave's bit.
                     sclk_nxt = 1'b1;
                     rx_nxt   = {rx[46:0], miso};
                  end else begin
                     // Falling edge: present the next command bit.
                     sclk_nxt = 1'b0;
                     tx_nxt   = {tx[62:0], 1'b0};
                     mosi_nxt = tx[62];
                  end
               end
            end
         end

         S_CFG_GAP: begin
            if (div_cnt == DIV_LAST) begin
               init_done_nxt = 1'b1;
               start_read    = 1'b1;
            end else begin
               div_cnt_nxt = div_cnt + DW'(1);
            end
         end

         S_UPDATE: begin
            acl_data_nxt   = {axis_field(rx[47:40], rx[39:32]),
                              axis_field(rx[31:24], rx[23:16]),
                              axis_field(rx[15:8],  rx[7:0])};
            data_valid_nxt = 1'b1;
            div_cnt_nxt    = div_cnt + DW'(1);
            state_nxt      = S_WAIT;
         end

         S_WAIT: begin
            // div_cnt keeps counting the cs_n-high gap; it must elapse before the timer may start a read.
            if (div_cnt != DIV_LAST)
               div_cnt_nxt = div_cnt + DW'(1);
            else if (tmr == TMR_LAST)
               start_read = 1'b1;
         end

         default: state_nxt = S_STARTUP;
      endcase

      if (start_read) begin
         state_nxt   = S_READ;
         cs_n_nxt    = 1'b0;
         tx_nxt      = READ_WORD;
         mosi_nxt    = READ_WORD[63];
         div_cnt_nxt = '0;
         ph_nxt      = '0;
         tmr_nxt     = '0;
      end
   end

   // State and registered outputs; reset drops everything back to the startup delay.
   always_ff @(posedge clk100mhz or posedge reset) begin
      if (reset) begin
         state      <= S_STARTUP;
         su_cnt     <= '0;
         div_cnt    <= '0;
         ph         <= '0;
         tx         <= '0;
         rx         <= '0;
         tmr        <= '0;
         sclk       <= 1'b0;
         mosi       <= 1'b0;
         cs_n       <= 1'b1;
         acl_data   <= '0;
         data_valid <= 1'b0;
         init_done  <= 1'b0;
      end else begin
         state      <= state_nxt;
         su_cnt     <= su_cnt_nxt;
         div_cnt    <= div_cnt_nxt;
         ph         <= ph_nxt;
         tx         <= tx_nxt;
         rx         <= rx_nxt;
         tmr        <= tmr_nxt;
         sclk       <= sclk_nxt;
         mosi       <= mosi_nxt;
         cs_n       <= cs_n_nxt;
         acl_data   <= acl_data_nxt;
         data_valid <= data_valid_nxt;
         init_done  <= init_done_nxt;
      end
   end

endmodule

// File: tb/tb_adxl362_spi_reader.sv
// Directed bench for adxl362_spi_reader with a behavioural ADXL362 slave.
// Latency: checks frame lengths, gaps and data_valid timing cycle-exactly.
// Backpressure: not applicable; a second instance with a short sample period exercises overrun.
module tb_adxl362_spi_reader;

   logic        clk100mhz;
   logic        reset;
   logic        miso;
   logic        sclk, mosi, cs_n;
   logic [14:0] acl_data;
   logic        data_valid, init_done;

   logic        ov_sclk, ov_mosi, ov_cs_n;
   logic [14:0] ov_acl_data;
   logic        ov_data_valid, ov_init_done;

   int          tests = 0;
   int          fails = 0;
   int          cyc   = 0;

   // Slave / monitor state
   logic [47:0] resp;
   logic [63:0] slv_word = '0;
   logic [63:0] mosi_cap = '0;
   int          rise_cnt = 0;

   adxl362_spi_reader #(.CLK_DIV(2), .SAMPLE_PERIOD(400), .STARTUP_CYCLES(10)) dut (
      .clk100mhz  (clk100mhz),
      .reset      (reset),
      .miso       (miso),
      .sclk       (sclk),
      .mosi       (mosi),
      .cs_n       (cs_n),
      .acl_data   (acl_data),
      .data_valid (data_valid),
      .init_done  (init_done)
   );

   adxl362_spi_reader #(.CLK_DIV(2), .SAMPLE_PERIOD(100), .STARTUP_CYCLES(10)) dut_ov (
      .clk100mhz  (clk100mhz),
      .reset      (reset),
      .miso       (1'b0),
      .sclk       (ov_sclk),
      .mosi       (ov_mosi),
      .cs_n       (ov_cs_n),
      .acl_data   (ov_acl_data),
      .data_valid (ov_data_valid),
      .init_done  (ov_init_done)
   );

   initial clk100mhz = 1'b0;
   always #5 clk100mhz = ~clk100mhz;

   always @(posedge clk100mhz) cyc++;

   // Frame start latches the slave reply; each sclk rise records mosi and advances the reply bit.
   always @(negedge cs_n or posedge sclk) begin
      if (sclk === 1'b1) begin
         mosi_cap = {mosi_cap[62:0], mosi};
         rise_cnt++;
      end else begin
         mosi_cap = '0;
         rise_cnt = 0;
         slv_word = {16'h0, resp};
      end
   end

   assign miso = (rise_cnt < 64) ? slv_word[6'(63 - rise_cnt)] : 1'b0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk100mhz);
      #1;
   endtask

   task automatic wait_cs(input logic lvl, input int limit, output int n);
      n = 0;
      while (cs_n !== lvl && n < limit) begin
         tick();
         n++;
      end
   endtask

   task automatic count_low(output int n);
      n = 0;
      while (cs_n === 1'b0 && n < 5000) begin
         n++;
         tick();
      end
   endtask

   task automatic wait_dv(output int n);
      n = 0;
      while (data_valid !== 1'b1 && n < 1000) begin
         tick();
         n++;
      end
   endtask

   initial begin
      int          n;
      int          f0, dv0, r, bad;
      logic [14:0] acl_hold;

      reset = 1'b1;
      resp  = 48'hE8_03_18_FC_00_00;   // X=+1000, Y=-1000, Z=0
      repeat (3) @(posedge clk100mhz);
      #1;
      check("rst_ctl", {cs_n, sclk, mosi, data_valid, init_done}, 5'b10000);
      check("rst_acl", acl_data, 15'd0);

      // ---- config frame ----
      @(negedge clk100mhz) reset = 1'b0;
      wait_cs(1'b0, 100, n);
      check("startup_len", n, 10);
      count_low(n);
      check("cfg_low", n, 98);
      check("cfg_rises", rise_cnt, 24);
      check("cfg_word", mosi_cap[23:0], 24'h0A2D02);
      check("init_early", init_done, 1'b0);
      n = 0;
      while (init_done !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      check("init_delay", n, 2);

      // ---- first read ----
      f0 = cyc;
      count_low(n);
      check("rd_low", n, 258);
      check("rd_rises", rise_cnt, 64);
      check("rd_cmd", mosi_cap[63:48], 16'h0B0E);
      check("dv_early", data_valid, 1'b0);
      tick();
      check("dv_pulse", data_valid, 1'b1);
      check("acl_rd1", acl_data, 15'b0_0111_1_0111_0_0000);
      dv0      = cyc;
      acl_hold = acl_data;
      resp     = 48'h00_F8_7F_00_80_FF;   // X=-2048, Y=+127, Z=-128 (ZH upper nibble set)
      tick();
      check("dv_single", data_valid, 1'b0);

      // ---- periodicity and hold ----
      bad = 0;
      n   = 0;
      while (cs_n !== 1'b0 && n < 1000) begin
         if (acl_data !== acl_hold || data_valid !== 1'b0) bad++;
         tick();
         n++;
      end
      check("period_cs", cyc - f0, 400);
      n = 0;
      while (data_valid !== 1'b1 && n < 1000) begin
         if (acl_data !== acl_hold) bad++;
         tick();
         n++;
      end
      check("acl_hold", bad, 0);
      check("period_dv", cyc - dv0, 400);
      check("acl_sat", acl_data, 15'b1_1111_0_0000_1_0001);
      dv0  = cyc;
      resp = 48'h80_00_FF_07_FF_FF;       // X=+128, Y=+2047, Z=-1
      tick();
      wait_dv(n);
      check("period_dv2", cyc - dv0, 400);
      check("acl_rd3", acl_data, 15'b0_0001_0_1111_1_0000);

      // ---- overrun (SAMPLE_PERIOD=100) ----
      n = 0;
      while (ov_cs_n !== 1'b1 && n < 1000) begin
         tick();
         n++;
      end
      for (int k = 0; k < 2; k++) begin
         n = 0;
         while (ov_cs_n !== 1'b0 && n < 1000) begin
            tick();
            n++;
         end
         n = 0;
         while (ov_cs_n === 1'b0 && n < 1000) begin
            tick();
            n++;
         end
         if (k == 1) check("ovr_frame", n, 258);
         r = cyc;
         n = 0;
         while (ov_cs_n !== 1'b0 && n < 100) begin
            tick();
            n++;
         end
         check("ovr_gap", cyc - r, 2);
      end

      // ---- reset in the middle of a read ----
      wait_cs(1'b1, 1000, n);
      wait_cs(1'b0, 1000, n);
      n = 0;
      while (rise_cnt != 20 && n < 1000) begin
         tick();
         n++;
      end
      check("mid_rises", rise_cnt, 20);
      reset = 1'b1;
      #1;
      check("mid_rst_ctl", {cs_n, sclk, init_done, data_valid}, 4'b1000);
      check("mid_rst_acl", acl_data, 15'd0);
      @(negedge clk100mhz) reset = 1'b0;
      wait_cs(1'b0, 100, n);
      check("restart_len", n, 10);
      count_low(n);
      check("recfg_low", n, 98);
      check("recfg_rises", rise_cnt, 24);
      check("recfg_word", mosi_cap[23:0], 24'h0A2D02);
      check("reinit_early", init_done, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/adxl362_spi_reader.md
# adxl362_spi_reader

SPI master that configures the on-board ADXL362 accelerometer and periodically burst-reads its X/Y/Z 12-bit samples. It reduces each axis to a sign bit plus a 4-bit magnitude and packs them into the 15-bit `acl_data` word consumed by the 7-segment display driver. It sits between the board accelerometer pins and the display/game logic. Everything runs on the single 100 MHz system clock.

## Interface
- `CLK_DIV`, 50: `clk100mhz` cycles per SCLK half-period (50 gives 1 MHz SCLK); minimum 2.
- `SAMPLE_PERIOD`, 1_000_000: cycles between consecutive read-frame starts (100 Hz).
- `STARTUP_CYCLES`, 1_000_000: idle cycles after reset before the config frame.
- `clk100mhz`  in  1  system clock, 100 MHz.
- `reset`  in  1  reset; one clock, asynchronous, active-high.
- `miso`  in  1  SPI data from the ADXL362.
- `sclk`  out  1  SPI clock, mode 0 (idles low).
- `mosi`  out  1  SPI data to the ADXL362, MSB first.
- `cs_n`  out  1  chip select, active low.
- `acl_data`  out  15  fields {x_sign, x_mag[3:0], y_sign, y_mag[3:0], z_sign, z_mag[3:0]}, bits 14..0.
- `data_valid`  out  1  one-cycle pulse when `acl_data` updates.
- `init_done`  out  1  high once the config frame has completed.

## Operation
- Reset values:
  - `cs_n`=1, `sclk`=0, `mosi`=0.
  - `acl_data`=0, `data_valid`=0, `init_done`=0.
  - All counters cleared; state is `S_STARTUP`.
- FSM states:
  - `S_STARTUP`: count `STARTUP_CYCLES`, then go to `S_CFG`.
  - `S_CFG`: 24-bit frame 0x0A_2D_02 (write POWER_CTL = measure mode). Then `S_CFG_GAP`.
  - `S_CFG_GAP`: `cs_n` high for `CLK_DIV` cycles, set `init_done`=1, then `S_READ`.
  - `S_READ`: 64-bit frame. First 16 bits shift out 0x0B_0E (read command, address XDATA_L). The remaining 48 bits shift out 0 and shift in bytes b0..b5 = XL, XH, YL, YH, ZL, ZH. Then `S_UPDATE`.
  - `S_UPDATE`: one cycle; load `acl_data`, pulse `data_valid`. Then `S_WAIT`.
  - `S_WAIT`: `cs_n` high; go to `S_READ` when the sample timer expires.
- Frame mechanics (N bits):
  - `cs_n` falls and `mosi` presents bit N-1.
  - Per bit: `sclk` low for `CLK_DIV` cycles, then high for `CLK_DIV` cycles.
  - `miso` is sampled in the cycle `sclk` rises.
  - `mosi` changes only in the cycle `sclk` falls.
  - After the last high phase, `sclk` stays low for a further `CLK_DIV` cycles, then `cs_n` rises.
  - `cs_n` is low for exactly (2N+1)·`CLK_DIV` cycles.
- Axis arithmetic:
  - Sample: v = {H[3:0], L}, a 12-bit two's-complement value.
  - Sign: sign = v[11].
  - Magnitude: mag = sign ? −v : v, 11 bits. v = −2048 saturates to 2047.
  - Field: field = mag[10:7], i.e. 128 mg per step at ±2 g.
  - H[7:4] is ignored.
- Sample timer:
  - Restarts at every `cs_n` fall of a read frame.
  - When it reaches `SAMPLE_PERIOD`−1 in `S_WAIT`, the next read starts the following cycle.
  - If it expires before the frame and its `CLK_DIV` gap finish, the next read starts immediately after the gap. No frame is ever truncated.
- `acl_data` holds its value between updates and changes only in `S_UPDATE`.

## Timing
- `cs_n`, `sclk`, `mosi`, `acl_data`, `data_valid` and `init_done` are all registered outputs.
- First config `cs_n` fall: `STARTUP_CYCLES` cycles after reset deasserts.
- Read frame length: 129·`CLK_DIV` cycles (6450 at default).
- `data_valid` rises in the cycle after `cs_n` rises at the end of a read; `acl_data` is valid in that same cycle.
- Reset asserted mid-frame:
  - All outputs go to reset values immediately (asynchronous).
  - The partially shifted bytes are discarded.
  - After release the full sequence restarts: startup, then config.

## Test plan
Use `CLK_DIV`=2, `SAMPLE_PERIOD`=400, `STARTUP_CYCLES`=10 unless stated.
- **Config frame.** Release reset.
  - `cs_n` stays high 10 cycles, then is low 98 cycles.
  - 24 `sclk` rising edges; the `mosi` bits captured on them equal 0x0A2D02.
  - `init_done` rises 2 cycles after `cs_n` rises.
- **First read.** Slave model returns XL=E8, XH=03 (+1000), YL=18, YH=FC (−1000), ZL=00, ZH=00.
  - `mosi` on the first 16 edges equals 0x0B0E.
  - `acl_data` = 15'b0_0111_1_0111_0_0000, with a single `data_valid` pulse.
- **Saturation and rounding.** X = −2048 (XL=00, XH=F8) gives x field 1_1111. X = +127 gives 0_0000. X = −128 gives 1_0001.
- **Periodicity.** Consecutive read `cs_n` falls are exactly 400 cycles apart. `data_valid` pulses are 400 cycles apart. `acl_data` is stable between pulses.
- **Overrun.** `SAMPLE_PERIOD`=100 (shorter than the 258-cycle frame): each next frame starts exactly 2 cycles after the previous `cs_n` rise.
- **Reset mid-read.** Assert reset after the 20th `sclk` rise of a read.
  - Same cycle: `cs_n`=1, `sclk`=0, `acl_data`=0, `init_done`=0.
  - After release, the config frame 0x0A2D02 repeats before any read.
